// File: rtl/vending_pkg.sv
// Shared types and constants for the vending machine: FSM states, coin codes
// and the coin-to-value mapping used by both the credit logic and the change path.
package vending_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_CREDIT   = 2'd1,
    ST_DISPENSE = 2'd2,
    ST_CHANGE   = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    COIN_NONE = 2'b00,
    COIN_5    = 2'b01,
    COIN_10   = 2'b10,
    COIN_25   = 2'b11
  } coin_e;

  localparam int COIN_VAL_W = 5;
  localparam logic [COIN_VAL_W-1:0] VAL_5  = 5'd5;
  localparam logic [COIN_VAL_W-1:0] VAL_10 = 5'd10;
  localparam logic [COIN_VAL_W-1:0] VAL_25 = 5'd25;

  function automatic logic [COIN_VAL_W-1:0] coin_value(input logic [1:0] c);
    logic [COIN_VAL_W-1:0] v;
    case (c)
      COIN_5:  v = VAL_5;
      COIN_10: v = VAL_10;
      COIN_25: v = VAL_25;
      default: v = '0;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/change_dispenser.sv
// Change path: registers the coin offered to the customer (largest coin not
// exceeding the remaining credit, 5 for any sub-5 residue) and flags an accepted ack.
module change_dispenser
  import vending_pkg::*;
#(
  parameter int CREDIT_W = 7
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                load_i,
  input  logic [CREDIT_W-1:0] credit_next_i,
  input  logic                change_ack_i,
  output logic                change_valid_o,
  output logic [1:0]          change_coin_o,
  output logic                take_o,
  output logic [CREDIT_W-1:0] take_value_o
);

  logic       valid_q;
  logic [1:0] coin_q, coin_d;

  function automatic logic [1:0] largest_coin(input logic [CREDIT_W-1:0] c);
    logic [1:0] r;
    if (c >= CREDIT_W'(VAL_25))      r = COIN_25;
    else if (c >= CREDIT_W'(VAL_10)) r = COIN_10;
    else                             r = COIN_5;
    return r;
  endfunction

  always_comb begin
    coin_d = COIN_NONE;
    if (load_i) coin_d = largest_coin(credit_next_i);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= 1'b0;
      coin_q  <= COIN_NONE;
    end else begin
      valid_q <= load_i;
      coin_q  <= coin_d;
    end
  end

  assign change_valid_o = valid_q;
  assign change_coin_o  = coin_q;
  assign take_o         = valid_q & change_ack_i;
  assign take_value_o   = CREDIT_W'(coin_value(coin_q));

endmodule

// File: rtl/vending_machine_change.sv
// Vending machine top: credit accumulation, vend decisions, per-item stock and
// the IDLE/CREDIT/DISPENSE/CHANGE FSM; change coins come from change_dispenser.
module vending_machine_change
  import vending_pkg::*;
#(
  parameter int                            ITEM_COUNT = 4,
  parameter int                            CREDIT_W   = 7,
  parameter int                            MAX_CREDIT = 100,
  parameter logic [ITEM_COUNT*CREDIT_W-1:0] PRICES    = {7'd50, 7'd40, 7'd25, 7'd15},
  parameter int                            STOCK_W    = 4,
  parameter int                            STOCK_MAX  = 10,
  localparam int                           IW         = $clog2(ITEM_COUNT)
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic [1:0]            coin_i,
  input  logic [IW-1:0]         item_sel_i,
  input  logic                  vend_req_i,
  input  logic                  cancel_i,
  input  logic                  refill_i,
  input  logic                  change_ack_i,
  output logic                  dispense_o,
  output logic [IW-1:0]         item_out_o,
  output logic [CREDIT_W-1:0]   credit_o,
  output logic                  coin_reject_o,
  output logic                  vend_denied_o,
  output logic                  change_valid_o,
  output logic [1:0]            change_coin_o,
  output logic [ITEM_COUNT-1:0] sold_out_o
);

  state_e                  state_q, state_d;
  logic [CREDIT_W-1:0]     credit_q, credit_d;
  logic [STOCK_W-1:0]      stock_q [ITEM_COUNT];
  logic [STOCK_W-1:0]      stock_d [ITEM_COUNT];
  logic [ITEM_COUNT-1:0]   sold_out_q, sold_out_d;
  logic                    dispense_q, dispense_d;
  logic [IW-1:0]           item_out_q, item_out_d;
  logic                    coin_reject_q, coin_reject_d;
  logic                    vend_denied_q, vend_denied_d;
  logic [CREDIT_W-1:0]     price_tbl [ITEM_COUNT];
  logic [CREDIT_W:0]       coin_sum;
  logic                    coin_present;
  logic                    sel_ok;
  logic                    take;
  logic [CREDIT_W-1:0]     take_value;

  for (genvar g = 0; g < ITEM_COUNT; g++) begin : g_price
    assign price_tbl[g] = PRICES[g*CREDIT_W +: CREDIT_W];
  end

  assign coin_present = (coin_i != COIN_NONE);
  assign coin_sum     = {1'b0, credit_q} + (CREDIT_W+1)'(coin_value(coin_i));
  assign sel_ok       = (int'(item_sel_i) < ITEM_COUNT);

  // Priority inside IDLE/CREDIT is cancel > vend > coin; a losing coin is always refused.
  always_comb begin
    state_d       = state_q;
    credit_d      = credit_q;
    stock_d       = stock_q;
    dispense_d    = 1'b0;
    item_out_d    = item_out_q;
    coin_reject_d = 1'b0;
    vend_denied_d = 1'b0;

    case (state_q)
      ST_IDLE, ST_CREDIT: begin
        if (refill_i && state_q == ST_IDLE) begin
          for (int i = 0; i < ITEM_COUNT; i++) stock_d[i] = STOCK_W'(STOCK_MAX);
        end
        if (cancel_i && state_q == ST_CREDIT) begin
          state_d       = ST_CHANGE;
          coin_reject_d = coin_present;
        end else if (vend_req_i) begin
          coin_reject_d = coin_present;
          if (sel_ok && credit_q >= price_tbl[item_sel_i] && stock_q[item_sel_i] != '0) begin
            state_d             = ST_DISPENSE;
            credit_d            = credit_q - price_tbl[item_sel_i];
            stock_d[item_sel_i] = stock_q[item_sel_i] - STOCK_W'(1);
            dispense_d          = 1'b1;
            item_out_d          = item_sel_i;
          end else begin
            vend_denied_d = 1'b1;
          end
        end else if (coin_present) begin
          if (coin_sum > (CREDIT_W+1)'(MAX_CREDIT)) begin
            coin_reject_d = 1'b1;
          end else begin
            credit_d = coin_sum[CREDIT_W-1:0];
            state_d  = ST_CREDIT;
          end
        end
      end
      ST_DISPENSE: begin
        coin_reject_d = coin_present;
        state_d       = (credit_q != '0) ? ST_CHANGE : ST_IDLE;
      end
      ST_CHANGE: begin
        coin_reject_d = coin_present;
        if (take) credit_d = (credit_q > take_value) ? credit_q - take_value : '0;
        if (credit_d == '0) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    sold_out_d = '0;
    for (int i = 0; i < ITEM_COUNT; i++) sold_out_d[i] = (stock_d[i] == '0);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= ST_IDLE;
      credit_q      <= '0;
      for (int i = 0; i < ITEM_COUNT; i++) stock_q[i] <= STOCK_W'(STOCK_MAX);
      sold_out_q    <= '0;
      dispense_q    <= 1'b0;
      item_out_q    <= '0;
      coin_reject_q <= 1'b0;
      vend_denied_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      credit_q      <= credit_d;
      stock_q       <= stock_d;
      sold_out_q    <= sold_out_d;
      dispense_q    <= dispense_d;
      item_out_q    <= item_out_d;
      coin_reject_q <= coin_reject_d;
      vend_denied_q <= vend_denied_d;
    end
  end

  change_dispenser #(.CREDIT_W(CREDIT_W)) u_change (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .load_i         (state_d == ST_CHANGE),
    .credit_next_i  (credit_d),
    .change_ack_i   (change_ack_i),
    .change_valid_o (change_valid_o),
    .change_coin_o  (change_coin_o),
    .take_o         (take),
    .take_value_o   (take_value)
  );

  assign dispense_o    = dispense_q;
  assign item_out_o    = item_out_q;
  assign credit_o      = credit_q;
  assign coin_reject_o = coin_reject_q;
  assign vend_denied_o = vend_denied_q;
  assign sold_out_o    = sold_out_q;

endmodule
